// File: rtl/sh7604_mac_seq_if.sv
// Signal bundle between the MAC.W/MAC.L operand-fetch sequencer and its environment
// (core control, memory read bus and multiplier). master = sequencer, slave = environment.
interface sh7604_mac_seq_if;
  localparam int unsigned DW = 32;

  logic          CE_R;
  logic          EN;
  logic          START;
  logic          OP_L;
  logic          S_IN;
  logic          SAME_REG;
  logic [DW-1:0] RM_VAL;
  logic [DW-1:0] RN_VAL;
  logic [DW-1:0] BUS_A;
  logic          BUS_REQ;
  logic [DW-1:0] BUS_DI;
  logic          BUS_ACK;
  logic [DW-1:0] MAC_A;
  logic [DW-1:0] MAC_D;
  logic [1:0]    MAC_SEL;
  logic [3:0]    MAC_OP;
  logic          MAC_S;
  logic          MAC_WE;
  logic [DW-1:0] RM_NEW;
  logic [DW-1:0] RN_NEW;
  logic          RM_WE;
  logic          RN_WE;
  logic          BUSY;
  logic          DONE;
  logic          ADDR_ERR;

  modport master (
    input  CE_R, EN, START, OP_L, S_IN, SAME_REG, RM_VAL, RN_VAL, BUS_DI, BUS_ACK,
    output BUS_A, BUS_REQ, MAC_A, MAC_D, MAC_SEL, MAC_OP, MAC_S, MAC_WE,
           RM_NEW, RN_NEW, RM_WE, RN_WE, BUSY, DONE, ADDR_ERR
  );

  modport slave (
    output CE_R, EN, START, OP_L, S_IN, SAME_REG, RM_VAL, RN_VAL, BUS_DI, BUS_ACK,
    input  BUS_A, BUS_REQ, MAC_A, MAC_D, MAC_SEL, MAC_OP, MAC_S, MAC_WE,
           RM_NEW, RN_NEW, RM_WE, RN_WE, BUSY, DONE, ADDR_ERR
  );
endinterface

// File: rtl/sh7604_mac_seq.sv
// Operand-fetch sequencer for MAC.W / MAC.L @Rm+,@Rn+: reads @Rm then @Rn, forwards each
// word to the multiplier, returns post-incremented registers and covers the accumulate cycle.
module sh7604_mac_seq (
  input  logic             CLK,
  input  logic             RST,
  sh7604_mac_seq_if.master io
);
  localparam int unsigned AW  = 32;
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_MACL = 4'b1001;
  localparam logic [OPW-1:0] OP_MACW = 4'b1011;

  typedef enum logic [2:0] {IDLE, RD_M, RD_N, ACC, FIN} state_e;

  state_e          state_q, state_d;
  logic            op_l_q, op_l_d;
  logic            s_q, s_d;
  logic [AW-1:0]   am_q, am_d;
  logic [AW-1:0]   an_q, an_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bus_req_q, bus_req_d;
  logic            addr_err_q, addr_err_d;
  logic            mac_s_q, mac_s_d;
  logic [OPW-1:0]  mac_op_q, mac_op_d;
  logic [AW-1:0]   bus_a_q, bus_a_d;
  logic [AW-1:0]   rm_new_q, rm_new_d;
  logic [AW-1:0]   rn_new_q, rn_new_d;
  logic [AW-1:0]   start_sz;
  logic [AW-1:0]   sz_d;
  logic            ack_c;

  function automatic logic misaligned(input logic [AW-1:0] a, input logic l);
    return l ? (a[1:0] != 2'b00) : a[0];
  endfunction

  // Next state plus the registered output image of that next state
  always_comb begin
    start_sz = io.OP_L ? AW'(4) : AW'(2);
    state_d  = state_q;
    op_l_d   = op_l_q;
    s_d      = s_q;
    am_d     = am_q;
    an_d     = an_q;

    case (state_q)
      IDLE: begin
        if (io.START && io.EN) begin
          op_l_d  = io.OP_L;
          s_d     = io.S_IN;
          am_d    = io.RM_VAL;
          an_d    = io.SAME_REG ? io.RM_VAL + start_sz : io.RN_VAL;
          state_d = RD_M;
        end
      end
      RD_M: begin
        if (addr_err_q)      state_d = IDLE;
        else if (io.BUS_ACK) state_d = RD_N;
      end
      RD_N: begin
        if (addr_err_q)      state_d = IDLE;
        else if (io.BUS_ACK) state_d = ACC;
      end
      ACC:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sz_d       = op_l_d ? AW'(4) : AW'(2);
    busy_d     = (state_d == RD_M) || (state_d == RD_N) || (state_d == ACC);
    done_d     = (state_d == FIN);
    mac_op_d   = busy_d ? (op_l_d ? OP_MACL : OP_MACW) : '0;
    mac_s_d    = busy_d & s_d;
    bus_a_d    = '0;
    addr_err_d = 1'b0;
    if (state_d == RD_M) begin
      bus_a_d    = am_d;
      addr_err_d = misaligned(am_d, op_l_d);
    end else if (state_d == RD_N) begin
      bus_a_d    = an_d;
      addr_err_d = misaligned(an_d, op_l_d);
    end
    // A misaligned operand never raises a request; the error pulse replaces it
    bus_req_d = ((state_d == RD_M) || (state_d == RD_N)) && !addr_err_d;
    rm_new_d  = (state_d == IDLE) ? '0 : am_d + sz_d;
    rn_new_d  = (state_d == IDLE) ? '0 : an_d + sz_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      op_l_q     <= 1'b0;
      s_q        <= 1'b0;
      am_q       <= '0;
      an_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      addr_err_q <= 1'b0;
      mac_s_q    <= 1'b0;
      mac_op_q   <= '0;
      bus_a_q    <= '0;
      rm_new_q   <= '0;
      rn_new_q   <= '0;
    end else if (io.CE_R) begin
      state_q    <= state_d;
      op_l_q     <= op_l_d;
      s_q        <= s_d;
      am_q       <= am_d;
      an_q       <= an_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_req_q  <= bus_req_d;
      addr_err_q <= addr_err_d;
      mac_s_q    <= mac_s_d;
      mac_op_q   <= mac_op_d;
      bus_a_q    <= bus_a_d;
      rm_new_q   <= rm_new_d;
      rn_new_q   <= rn_new_d;
    end
  end

  // Ack is consumed only on an enabled cycle, so the strobes fire exactly once per read
  assign ack_c = io.CE_R & io.BUS_ACK & bus_req_q;

  assign io.MAC_WE   = ack_c;
  assign io.MAC_SEL  = {ack_c & (state_q == RD_N), ack_c & (state_q == RD_M)};
  assign io.RM_WE    = ack_c & (state_q == RD_M);
  assign io.RN_WE    = ack_c & (state_q == RD_N);
  assign io.BUS_A    = bus_a_q;
  assign io.MAC_A    = bus_a_q;
  assign io.MAC_D    = io.BUS_DI;
  assign io.BUS_REQ  = bus_req_q;
  assign io.MAC_OP   = mac_op_q;
  assign io.MAC_S    = mac_s_q;
  assign io.RM_NEW   = rm_new_q;
  assign io.RN_NEW   = rn_new_q;
  assign io.BUSY     = busy_q;
  assign io.DONE     = done_q;
  assign io.ADDR_ERR = addr_err_q;
endmodule

// File: tb/tb_sh7604_mac_seq.sv
// Bench for sh7604_mac_seq: transaction-level expectations per cycle from a straight-line
// description of each MAC sequence, plus literal pins taken from the directed scenarios.
module tb_sh7604_mac_seq;
  logic CLK = 1'b0;
  logic RST;

  sh7604_mac_seq_if io ();

  sh7604_mac_seq dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io.master)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        busy, done, req, err, we, rm_we, rn_we, s, a_chk, op_chk;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic [31:0] a, rm_new, rn_new;
  } exp_t;

  exp_t        exp_v;
  bit          chk_on;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  bit          pin_req;
  string       pin_name;
  logic [31:0] pin_got, pin_want;

  // Monitor state, written only by the compare process
  logic [1:0]  mon_sel[$];
  logic [31:0] mon_a[$];
  logic [31:0] mon_d[$];
  int          mon_err_n = 0, mon_req_n = 0, mon_rmwe_n = 0, mon_rnwe_n = 0;
  logic [31:0] mon_rm = '0, mon_rn = '0;
  int          mon_lat = 0, busy_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endfunction

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("BUSY",     32'(io.BUSY),     32'(exp_v.busy));
      chk("DONE",     32'(io.DONE),     32'(exp_v.done));
      chk("BUS_REQ",  32'(io.BUS_REQ),  32'(exp_v.req));
      chk("ADDR_ERR", 32'(io.ADDR_ERR), 32'(exp_v.err));
      chk("MAC_WE",   32'(io.MAC_WE),   32'(exp_v.we));
      chk("MAC_SEL",  32'(io.MAC_SEL),  32'(exp_v.sel));
      chk("RM_WE",    32'(io.RM_WE),    32'(exp_v.rm_we));
      chk("RN_WE",    32'(io.RN_WE),    32'(exp_v.rn_we));
      chk("MAC_D",    io.MAC_D,         io.BUS_DI);
      if (exp_v.a_chk) begin
        chk("BUS_A", io.BUS_A, exp_v.a);
        chk("MAC_A", io.MAC_A, exp_v.a);
      end
      if (exp_v.op_chk) begin
        chk("MAC_OP", 32'(io.MAC_OP), 32'(exp_v.op));
        chk("MAC_S",  32'(io.MAC_S),  32'(exp_v.s));
      end
      if (exp_v.rm_we) chk("RM_NEW", io.RM_NEW, exp_v.rm_new);
      if (exp_v.rn_we) chk("RN_NEW", io.RN_NEW, exp_v.rn_new);
    end
    if (pin_req) chk(pin_name, pin_got, pin_want);

    if (io.MAC_WE) begin
      mon_sel.push_back(io.MAC_SEL);
      mon_a.push_back(io.MAC_A);
      mon_d.push_back(io.MAC_D);
    end
    if (io.RM_WE) begin mon_rm = io.RM_NEW; mon_rmwe_n++; end
    if (io.RN_WE) begin mon_rn = io.RN_NEW; mon_rnwe_n++; end
    if (io.BUS_REQ) mon_req_n++;
    if (io.CE_R) begin
      if (io.ADDR_ERR) mon_err_n++;
      if (io.BUSY) busy_cnt++;
      if (io.DONE) begin mon_lat = busy_cnt + 1; busy_cnt = 0; end
      if (!io.BUSY && !io.DONE) busy_cnt = 0;
    end
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    pin_name = name; pin_got = got; pin_want = want; pin_req = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    pin_req = 1'b0;
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.a_chk  = 1'b1;
    e.op_chk = 1'b1;
    return e;
  endfunction

  function automatic logic ce_for(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return 1'(cyc);
      default: return 1'($urandom);
    endcase
  endfunction

  // Noise on inputs that must be ignored while a sequence is running
  task automatic scramble();
    io.START    = 1'($urandom);
    io.EN       = 1'($urandom);
    io.OP_L     = 1'($urandom);
    io.S_IN     = 1'($urandom);
    io.SAME_REG = 1'($urandom);
    io.RM_VAL   = $urandom;
    io.RN_VAL   = $urandom;
    io.BUS_DI   = $urandom;
    io.BUS_ACK  = 1'b0;
  endtask

  // Idle cycle whose START is never accepted (EN or CE_R withheld)
  task automatic quiet_idle();
    scramble();
    io.CE_R = 1'($urandom);
    if (io.START && io.EN && io.CE_R) io.CE_R = 1'b0;
  endtask

  // One operand read; res: 0 = consumed ack, 1 = alignment error, 2 = aborted by reset
  task automatic read_phase(input logic [31:0] addr, input logic first, input logic opl, input logic s,
                            input logic [31:0] data, input int wait_n, input int ce_mode,
                            input int rst_after, output int res);
    logic [31:0] sz;
    logic        mis;
    exp_t        e;
    int          n;
    sz  = opl ? 32'd4 : 32'd2;
    mis = (addr % sz) != 0;
    n   = 0;
    res = -1;
    while (res < 0) begin
      scramble();
      io.CE_R    = (n > 40) ? 1'b1 : ce_for(ce_mode);
      io.BUS_ACK = (n >= wait_n);
      io.BUS_DI  = data;
      if (rst_after >= 0 && n == rst_after) begin
        io.BUS_ACK = 1'b0;
        RST        = 1'b1;
        exp_v      = idle_exp();
        res        = 2;
      end else begin
        e        = '0;
        e.busy   = 1'b1;
        e.a_chk  = 1'b1;
        e.a      = addr;
        e.op_chk = 1'b1;
        e.op     = opl ? 4'b1001 : 4'b1011;
        e.s      = s;
        e.err    = mis;
        e.req    = !mis;
        if (!mis && io.CE_R && io.BUS_ACK) begin
          e.we     = 1'b1;
          e.sel    = first ? 2'b01 : 2'b10;
          e.rm_we  = first;
          e.rn_we  = !first;
          e.rm_new = addr + sz;
          e.rn_new = addr + sz;
          res      = 0;
        end else if (mis && io.CE_R) begin
          res = 1;
        end
        exp_v = e;
      end
      next_cycle();
      n++;
    end
  endtask

  task automatic run_mac(input logic opl, input logic s, input logic same,
                         input logic [31:0] rm, input logic [31:0] rn,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input int w1, input int w2, input int ce_mode, input int rst_after);
    logic [31:0] sz, an;
    int          res;
    logic        ce;
    exp_t        e;
    sz = opl ? 32'd4 : 32'd2;
    an = same ? rm + sz : rn;

    repeat ($urandom_range(0, 3)) begin
      quiet_idle();
      exp_v = idle_exp();
      next_cycle();
    end

    scramble();
    io.START = 1'b1; io.EN = 1'b1; io.CE_R = 1'b1;
    io.OP_L = opl; io.S_IN = s; io.SAME_REG = same; io.RM_VAL = rm; io.RN_VAL = rn;
    exp_v = idle_exp();
    next_cycle();

    read_phase(rm, 1'b1, opl, s, d1, w1, ce_mode, -1, res);
    if (res == 0) read_phase(an, 1'b0, opl, s, d2, w2, ce_mode, rst_after, res);

    if (res == 0) begin
      do begin
        scramble();
        io.CE_R  = ce_for(ce_mode);
        e        = '0;
        e.busy   = 1'b1;
        e.op_chk = 1'b1;
        e.op     = opl ? 4'b1001 : 4'b1011;
        e.s      = s;
        exp_v    = e;
        ce       = io.CE_R;
        next_cycle();
      end while (!ce);
      do begin
        scramble();
        io.CE_R = ce_for(ce_mode);
        e       = '0;
        e.done  = 1'b1;
        exp_v   = e;
        ce      = io.CE_R;
        next_cycle();
      end while (!ce);
    end else if (res == 2) begin
      quiet_idle();
      exp_v = idle_exp();
      next_cycle();
      RST = 1'b0;
    end

    quiet_idle();
    exp_v = idle_exp();
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_we, b_err, b_req, b_rmwe, b_rnwe;
    logic        opl, s, same;
    logic [31:0] rm, rn;
    int          rst_after;

    RST = 1'b1; pin_req = 1'b0; chk_on = 1'b0;
    io.CE_R = 1'b0; io.EN = 1'b0; io.START = 1'b0; io.OP_L = 1'b0; io.S_IN = 1'b0;
    io.SAME_REG = 1'b0; io.RM_VAL = '0; io.RN_VAL = '0; io.BUS_DI = '0; io.BUS_ACK = 1'b0;
    exp_v  = idle_exp();
    chk_on = 1'b1;
    repeat (2) next_cycle();
    pin("reset RM_NEW", io.RM_NEW, 32'h0);
    pin("reset RN_NEW", io.RN_NEW, 32'h0);
    RST = 1'b0;
    next_cycle();

    // MAC.L, immediate acks
    b_we = mon_sel.size();
    run_mac(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h0000_0003, 32'hFFFF_FFFE, 0, 0, 0, -1);
    pin("macl we count", 32'(mon_sel.size() - b_we), 32'd2);
    pin("macl sel first", 32'(mon_sel[b_we]), 32'd1);
    pin("macl sel second", 32'(mon_sel[b_we + 1]), 32'd2);
    pin("macl data first", mon_d[b_we], 32'h0000_0003);
    pin("macl data second", mon_d[b_we + 1], 32'hFFFF_FFFE);
    pin("macl RM_NEW", mon_rm, 32'h0000_1004);
    pin("macl RN_NEW", mon_rn, 32'h0000_2004);
    pin("macl latency", 32'(mon_lat), 32'd4);

    // MAC.W, same register
    b_we = mon_sel.size();
    run_mac(1'b0, 1'b0, 1'b1, 32'h0000_3002, 32'h1234_5678, 32'h1111_2222, 32'h3333_4444, 0, 0, 0, -1);
    pin("samereg addr first", mon_a[b_we], 32'h0000_3002);
    pin("samereg addr second", mon_a[b_we + 1], 32'h0000_3004);
    pin("samereg RM_NEW", mon_rm, 32'h0000_3004);
    pin("samereg RN_NEW", mon_rn, 32'h0000_3006);

    // MAC.L misaligned Rm
    b_we = mon_sel.size(); b_err = mon_err_n; b_req = mon_req_n; b_rmwe = mon_rmwe_n;
    run_mac(1'b1, 1'b0, 1'b0, 32'h0000_1002, 32'h0000_2000, 32'h5, 32'h6, 0, 0, 0, -1);
    pin("misalign err count", 32'(mon_err_n - b_err), 32'd1);
    pin("misalign req count", 32'(mon_req_n - b_req), 32'd0);
    pin("misalign we count", 32'(mon_sel.size() - b_we), 32'd0);
    pin("misalign rm_we count", 32'(mon_rmwe_n - b_rmwe), 32'd0);

    // MAC.W misaligned Rn after a completed Rm read
    b_err = mon_err_n; b_rmwe = mon_rmwe_n; b_rnwe = mon_rnwe_n;
    run_mac(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0021, 32'h7, 32'h8, 1, 0, 0, -1);
    pin("rn misalign err", 32'(mon_err_n - b_err), 32'd1);
    pin("rn misalign rm_we", 32'(mon_rmwe_n - b_rmwe), 32'd1);
    pin("rn misalign rn_we", 32'(mon_rnwe_n - b_rnwe), 32'd0);
    pin("rn misalign RM_NEW", mon_rm, 32'h0000_0012);

    // Second ack delayed, CE_R toggling
    b_we = mon_sel.size();
    run_mac(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'hA, 32'hB, 0, 5, 1, -1);
    pin("delayed we count", 32'(mon_sel.size() - b_we), 32'd2);
    pin("delayed sel second", 32'(mon_sel[b_we + 1]), 32'd2);
    pin("delayed addr second", mon_a[b_we + 1], 32'h0000_0200);

    // Address wrap
    run_mac(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0040, 32'h1, 32'h2, 0, 0, 0, -1);
    pin("wrap RM_NEW", mon_rm, 32'h0000_0000);

    // Reset while waiting on the second read, then a clean sequence
    b_rnwe = mon_rnwe_n;
    run_mac(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h1, 32'h2, 0, 10, 0, 3);
    pin("abort rn_we", 32'(mon_rnwe_n - b_rnwe), 32'd0);
    run_mac(1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0600, 32'h3, 32'h4, 0, 0, 0, -1);
    pin("post reset RM_NEW", mon_rm, 32'h0000_0502);
    pin("post reset RN_NEW", mon_rn, 32'h0000_0602);
    pin("post reset latency", 32'(mon_lat), 32'd4);

    // Randomized sequences
    for (int i = 0; i < 60; i++) begin
      opl  = 1'($urandom);
      s    = 1'($urandom);
      same = ($urandom_range(0, 3) == 0);
      rm   = $urandom & 32'hFFFF_FFFC;
      rn   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rm = rm | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rn = rn | 32'($urandom_range(1, 3));
      rst_after = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_mac(opl, s, same, rm, rn, $urandom, $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 2)), rst_after);
    end

    chk_on = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
